mem_debug_port: RTL and testbench

- Byte-stream debug responder inside the processor top level.
- An external host loads instruction memory and reads or writes data memory through it, replacing hierarchical preload/peek with real hardware.
- It halts the pipeline, waits for a halt acknowledge, performs a single-word memory access, then returns an ack byte or the read data.
- It sits between the host link and the imem/dmem write/read ports.

---
 rtl/mem_debug_port.sv | 173 +++++++++++++++++
 tb/tb_mem_debug_port.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_debug_port.sv
// Byte-stream debug responder: halts the pipeline, performs one imem/dmem word
// access per host frame, then returns an ack byte or the four read-data bytes.
module mem_debug_port #(
    parameter int          ADDR_W   = 8,
    parameter logic [7:0]  ACK_BYTE = 8'hAA,
    parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic              cpu_halt,
    input  logic              cpu_halted,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int         ABYTES = (ADDR_W + 7) / 8;
    localparam logic [2:0] ALAST  = 3'(ABYTES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_WDATA     = 3'd2;
    localparam logic [2:0] S_WAIT_HALT = 3'd3;
    localparam logic [2:0] S_ACCESS    = 3'd4;
    localparam logic [2:0] S_RDWAIT    = 3'd5;
    localparam logic [2:0] S_RESP      = 3'd6;

    logic [2:0]          state_q,     state_d;
    logic [2:0]          acnt_q,      acnt_d;
    logic [1:0]          wcnt_q,      wcnt_d;
    logic [1:0]          rcnt_q,      rcnt_d;
    logic [ABYTES*8-1:0] addr_buf_q,  addr_buf_d;
    logic [23:0]         rsp_shift_q, rsp_shift_d;
    logic                cpu_halt_q,  cpu_halt_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic                mem_sel_q,   mem_sel_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [7:0]          rsp_data_q,  rsp_data_d;

    always_comb begin
        state_d     = state_q;
        acnt_d      = acnt_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        addr_buf_d  = addr_buf_q;
        rsp_shift_d = rsp_shift_q;
        cpu_halt_d  = cpu_halt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                case (cmd_data)
                    8'h01, 8'h02, 8'h03, 8'h04: begin
                        state_d    = S_ADDR;
                        cpu_halt_d = 1'b1;
                        acnt_d     = '0;
                        mem_we_d   = (cmd_data == 8'h01) || (cmd_data == 8'h02);
                        mem_sel_d  = (cmd_data == 8'h02) || (cmd_data == 8'h03);
                    end
                    default: begin
                        state_d    = S_RESP;
                        rsp_data_d = ERR_BYTE;
                        rcnt_d     = '0;
                    end
                endcase
            end
            S_ADDR: if (cmd_valid) begin
                addr_buf_d[{acnt_q, 3'b000} +: 8] = cmd_data;
                mem_addr_d = addr_buf_d[ADDR_W-1:0];
                if (acnt_q == ALAST) begin
                    acnt_d  = '0;
                    state_d = mem_we_q ? S_WDATA : S_WAIT_HALT;
                end else begin
                    acnt_d = acnt_q + 3'd1;
                end
            end
            S_WDATA: if (cmd_valid) begin
                mem_wdata_d[{wcnt_q, 3'b000} +: 8] = cmd_data;
                wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == 2'd3) state_d = S_WAIT_HALT;
            end
            S_WAIT_HALT: if (cpu_halted) begin
                state_d   = S_ACCESS;
                mem_req_d = 1'b1;
            end
            S_ACCESS: begin
                if (mem_we_q) begin
                    state_d    = S_RESP;
                    rsp_data_d = ACK_BYTE;
                    rcnt_d     = '0;
                end else begin
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                // rcnt counts bytes still queued behind the one presented
                rsp_data_d  = mem_rdata[7:0];
                rsp_shift_d = mem_rdata[31:8];
                rcnt_d      = 2'd3;
                state_d     = S_RESP;
            end
            S_RESP: if (rsp_ready) begin
                if (rcnt_q == 2'd0) begin
                    state_d    = S_IDLE;
                    cpu_halt_d = 1'b0;
                end else begin
                    rsp_data_d  = rsp_shift_q[7:0];
                    rsp_shift_d = {8'h00, rsp_shift_q[23:8]};
                    rcnt_d      = rcnt_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acnt_q      <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            addr_buf_q  <= '0;
            rsp_shift_q <= '0;
            cpu_halt_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acnt_q      <= acnt_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            addr_buf_q  <= addr_buf_d;
            rsp_shift_q <= rsp_shift_d;
            cpu_halt_q  <= cpu_halt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign cpu_halt  = cpu_halt_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_sel   = mem_sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_debug_port.sv
// Directed bench for mem_debug_port with a small synchronous imem/dmem model.
module tb_mem_debug_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [7:0]  cmd_data, rsp_data;
    logic        cpu_halt, cpu_halted;
    logic        mem_req, mem_we, mem_sel;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    logic        preloaded = 1'b0;
    int          req_cnt   = 0;
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    mem_debug_port #(.ADDR_W(8), .ACK_BYTE(8'hAA), .ERR_BYTE(8'hEE)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .cpu_halt(cpu_halt), .cpu_halted(cpu_halted),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: read data appears the cycle after the request.
    always @(posedge clk) begin
        if (!preloaded) begin
            dmem[102]   <= 32'h0000000A;
            dmem[8'h20] <= 32'hCAFEF00D;
            preloaded   <= 1'b1;
        end
        if (mem_req) begin
            req_cnt <= req_cnt + 1;
            if (mem_we) begin
                if (mem_sel) dmem[mem_addr] <= mem_wdata;
                else         imem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem_sel ? dmem[mem_addr] : imem[mem_addr];
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (cmd_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL send_timeout cmd_ready got %b exp 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_data = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (rsp_valid !== 1'b1) begin
            total_cnt++;
            $display("FAIL recv_timeout rsp_valid got %b exp 1", rsp_valid);
        end
        b = rsp_data;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0; cpu_halted = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({cmd_ready, rsp_valid, cpu_halt, mem_req, mem_we, mem_sel} !== 6'b100000)
            $display("FAIL reset_ctrl got %b exp 100000", {cmd_ready, rsp_valid, cpu_halt, mem_req, mem_we, mem_sel});
        else pass_cnt++;
        total_cnt++;
        if ({rsp_data, mem_addr, mem_wdata} !== 48'h0)
            $display("FAIL reset_data got %h exp 0", {rsp_data, mem_addr, mem_wdata});
        else pass_cnt++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_dmem();
        logic [7:0] r;
        int c0 = req_cnt;
        cpu_halted = 1'b1;
        send_byte(8'h02);
        total_cnt++;
        if (cpu_halt !== 1'b1) $display("FAIL wr_halt_set got %b exp 1", cpu_halt); else pass_cnt++;
        send_byte(8'h64); send_byte(8'h14); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL wr_req_early got %b exp 0", mem_req); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({mem_req, mem_we, mem_sel, mem_addr, mem_wdata} !== {3'b111, 8'd100, 32'h00000014})
            $display("FAIL wr_access got req=%b we=%b sel=%b addr=%0d wdata=%h exp 1 1 1 100 00000014",
                     mem_req, mem_we, mem_sel, mem_addr, mem_wdata);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({mem_req, rsp_valid, cpu_halt, rsp_data} !== {3'b011, 8'hAA})
            $display("FAIL wr_resp got req=%b valid=%b halt=%b data=%h exp 0 1 1 aa",
                     mem_req, rsp_valid, cpu_halt, rsp_data);
        else pass_cnt++;
        recv_byte(r);
        total_cnt++;
        if ({cpu_halt, rsp_valid} !== 2'b00) $display("FAIL wr_halt_clear got %b exp 00", {cpu_halt, rsp_valid}); else pass_cnt++;
        total_cnt++;
        if (dmem[100] !== 32'h00000014 || req_cnt - c0 != 1)
            $display("FAIL wr_mem got dmem=%h reqs=%0d exp 00000014 1", dmem[100], req_cnt - c0);
        else pass_cnt++;
    endtask

    task automatic test_read_dmem();
        logic [7:0] exp_b [4];
        logic [7:0] r;
        int c0 = req_cnt;
        exp_b = '{8'h0A, 8'h00, 8'h00, 8'h00};
        cpu_halted = 1'b1;
        send_byte(8'h03); send_byte(8'h66);
        @(posedge clk); #1;
        total_cnt++;
        if ({mem_req, mem_we, mem_sel, mem_addr} !== {3'b101, 8'd102})
            $display("FAIL rd_access got req=%b we=%b sel=%b addr=%0d exp 1 0 1 102", mem_req, mem_we, mem_sel, mem_addr);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL rd_latency_early got %b exp 0", rsp_valid); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (rsp_valid !== 1'b1) $display("FAIL rd_latency got %b exp 1", rsp_valid); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            recv_byte(r);
            total_cnt++;
            if (r !== exp_b[i]) $display("FAIL rd_byte%0d got %h exp %h", i, r, exp_b[i]); else pass_cnt++;
        end
        total_cnt++;
        if (req_cnt - c0 != 1 || cpu_halt !== 1'b0)
            $display("FAIL rd_done got reqs=%0d halt=%b exp 1 0", req_cnt - c0, cpu_halt);
        else pass_cnt++;
    endtask

    task automatic test_halt_wait();
        logic [7:0] r;
        logic       ok = 1'b1;
        cpu_halted = 1'b0;
        send_byte(8'h01); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (mem_req !== 1'b0 || cpu_halt !== 1'b1 || cmd_ready !== 1'b0) ok = 1'b0;
        end
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL hw_wait got req=%b halt=%b exp 0 1", mem_req, cpu_halt); else pass_cnt++;
        cpu_halted = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({mem_req, mem_we, mem_sel, mem_addr, mem_wdata} !== {3'b110, 8'd5, 32'h44332211})
            $display("FAIL hw_access got req=%b we=%b sel=%b addr=%0d wdata=%h exp 1 1 0 5 44332211",
                     mem_req, mem_we, mem_sel, mem_addr, mem_wdata);
        else pass_cnt++;
        recv_byte(r);
        total_cnt++;
        if (r !== 8'hAA || imem[5] !== 32'h44332211)
            $display("FAIL hw_done got rsp=%h imem=%h exp aa 44332211", r, imem[5]);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b [4];
        logic [7:0] d0;
        logic       ok;
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        cpu_halted = 1'b1;
        send_byte(8'h04); send_byte(8'h05);
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 20 && rsp_valid !== 1'b1; n++) begin
                @(posedge clk); #1;
            end
            d0 = rsp_data;
            ok = rsp_valid;
            repeat (5) begin
                @(posedge clk); #1;
                if (rsp_valid !== 1'b1 || rsp_data !== d0) ok = 1'b0;
            end
            total_cnt++;
            if (ok !== 1'b1 || d0 !== exp_b[i])
                $display("FAIL bp_byte%0d got %h stable=%b exp %h stable=1", i, d0, ok, exp_b[i]);
            else pass_cnt++;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
        ok = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cpu_halt !== 1'b0) ok = 1'b0;
        end
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL bp_extra got valid=%b halt=%b exp 0 0", rsp_valid, cpu_halt); else pass_cnt++;
    endtask

    task automatic test_error();
        logic [7:0] r;
        logic       halt_seen;
        int c0 = req_cnt;
        send_byte(8'h7F);
        halt_seen = cpu_halt;
        total_cnt++;
        if ({rsp_valid, rsp_data} !== {1'b1, 8'hEE})
            $display("FAIL err_rsp got valid=%b data=%h exp 1 ee", rsp_valid, rsp_data);
        else pass_cnt++;
        recv_byte(r);
        halt_seen = halt_seen | cpu_halt;
        total_cnt++;
        if (halt_seen !== 1'b0 || req_cnt != c0)
            $display("FAIL err_halt got halt=%b reqs=%0d exp 0 0", halt_seen, req_cnt - c0);
        else pass_cnt++;
        send_byte(8'h02); send_byte(8'h10);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        recv_byte(r);
        total_cnt++;
        if (r !== 8'hAA || dmem[16] !== 32'h12345678)
            $display("FAIL err_next got rsp=%h dmem=%h exp aa 12345678", r, dmem[16]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_b [4];
        logic [7:0] r;
        int c0 = req_cnt;
        exp_b = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        cpu_halted = 1'b1;
        send_byte(8'h02); send_byte(8'h20); send_byte(8'h01); send_byte(8'h02);
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({cmd_ready, rsp_valid, cpu_halt, mem_req, mem_we, mem_sel, rsp_data, mem_addr, mem_wdata}
            !== {6'b100000, 48'h0})
            $display("FAIL rst_mid got rdy=%b halt=%b we=%b addr=%h wdata=%h exp 1 0 0 00 00000000",
                     cmd_ready, cpu_halt, mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send_byte(8'h03); send_byte(8'h20);
        for (int i = 0; i < 4; i++) begin
            recv_byte(r);
            total_cnt++;
            if (r !== exp_b[i]) $display("FAIL rst_read%0d got %h exp %h", i, r, exp_b[i]); else pass_cnt++;
        end
        total_cnt++;
        if (req_cnt - c0 != 1) $display("FAIL rst_reqs got %0d exp 1", req_cnt - c0); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_dmem();
        test_read_dmem();
        test_halt_wait();
        test_backpressure();
        test_error();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
